// File: rtl/xxd_line_sequencer.sv
// xxd-style line sequencer: buffers one line of input bytes, then emits
// "<offset>: <hex column>  <ascii column>\n" one character per cycle.
module xxd_line_sequencer #(
    parameter int BYTES_PER_LINE = 8,
    parameter int OFFSET_DIGITS  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam int CNT_W = ($clog2(BYTES_PER_LINE + 1) > 3) ? $clog2(BYTES_PER_LINE + 1) : 3;
    localparam int SEL_W = $clog2(BYTES_PER_LINE);
    localparam int OFF_W = 4 * OFFSET_DIGITS;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(BYTES_PER_LINE - 1);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(OFFSET_DIGITS - 1);

    typedef enum logic [2:0] {FILL, OFFSET, COLON_SP, HEX, SEP, ASCII, NL} state_t;

    state_t           state, nxt_state;
    logic [CNT_W-1:0] count, idx, nxt_idx, digit_pos;
    logic [1:0]       sub, nxt_sub;
    logic [OFF_W-1:0] offset;
    logic [3:0]       off_digit;
    logic             last_flag;
    logic             buf_we;
    logic [7:0]       sel_byte, nxt_char;
    logic [7:0]       line_buf [BYTES_PER_LINE];

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
    endfunction

    // Pointer (state, idx, sub) names the character currently on out_char;
    // sub selects high nibble, low nibble or group separator in HEX.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        nxt_state = state;
        nxt_idx   = idx;
        nxt_sub   = 2'd0;
        case (state)
            FILL: begin
                nxt_state = OFFSET;
                nxt_idx   = '0;
            end
            OFFSET: begin
                if (idx == LAST_DIGIT) begin
                    nxt_state = COLON_SP;
                    nxt_idx   = '0;
                end else nxt_idx = idx + 1'b1;
            end
            COLON_SP: begin
                if (idx != '0) begin
                    nxt_state = HEX;
                    nxt_idx   = '0;
                end else nxt_idx = idx + 1'b1;
            end
            HEX: begin
                if (sub == 2'd0) nxt_sub = 2'd1;
                else if (sub == 2'd1 && idx == LAST_IDX) begin
                    nxt_state = SEP;
                    nxt_idx   = '0;
                end else if (sub == 2'd1 && idx[0]) nxt_sub = 2'd2;
                else nxt_idx = idx + 1'b1;
            end
            SEP: begin
                if (idx != '0) begin
                    nxt_state = ASCII;
                    nxt_idx   = '0;
                end else nxt_idx = idx + 1'b1;
            end
            ASCII: begin
                if (idx + 1'b1 == count) begin
                    nxt_state = NL;
                    nxt_idx   = '0;
                end else nxt_idx = idx + 1'b1;
            end
            default: begin
                nxt_state = FILL;
                nxt_idx   = '0;
            end
        endcase
    end

    always_comb begin
        sel_byte  = line_buf[nxt_idx[SEL_W-1:0]];
        digit_pos = LAST_DIGIT - nxt_idx;
        off_digit = 4'(offset >> {digit_pos, 2'b00});
        nxt_char  = 8'h20;
        case (nxt_state)
            OFFSET:   nxt_char = hex_char(off_digit);
            COLON_SP: if (nxt_idx == '0) nxt_char = 8'h3a;
            HEX: begin
                if (nxt_sub != 2'd2 && nxt_idx < count)
                    nxt_char = hex_char((nxt_sub == 2'd0) ? sel_byte[7:4] : sel_byte[3:0]);
            end
            ASCII:    nxt_char = (sel_byte >= 8'h20 && sel_byte <= 8'h7e) ? sel_byte : 8'h2e;
            NL:       nxt_char = 8'h0a;
            default:  nxt_char = 8'h20;
        endcase
    end

    assign buf_we = (state == FILL) && in_valid && in_ready;

    // NOTE: the line buffer has no reset; clearing count is what discards its contents.
    always_ff @(posedge clk) begin
        if (buf_we) line_buf[count[SEL_W-1:0]] <= in_data;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            count     <= '0;
            idx       <= '0;
            sub       <= 2'd0;
            offset    <= '0;
            last_flag <= 1'b0;
            out_char  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        count <= count + 1'b1;
                        busy  <= 1'b1;
                        if (count == LAST_IDX || in_last) begin
                            state     <= nxt_state;
                            idx       <= nxt_idx;
                            sub       <= nxt_sub;
                            out_char  <= nxt_char;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            last_flag <= in_last;
                        end
                    end
                end
                default: begin
                    if (out_valid && out_ready) begin
                        state    <= nxt_state;
                        idx      <= nxt_idx;
                        sub      <= nxt_sub;
                        out_char <= nxt_char;
                        if (state == NL) begin
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            count     <= '0;
                            offset    <= last_flag ? '0 : offset + OFF_W'(count);
                        end
                    end
                end
            endcase
        end
    end

endmodule
